fd_n_counter: RTL

Programmable modulus counter that generates the `N_counter` phase count and the active modulus `N` consumed by the N-divider output stage of the FMDLL feedback path. It counts `clk_out` cycles from 0 to the active modulus and wraps, giving a period of N+1 cycles. New moduli from control logic are held in a shadow register and applied only at a period boundary, so the divider never sees a truncated or stretched period. An optional first-order fractional accumulator dithers the modulus by +1 on selected periods.

---
 rtl/fd_n_counter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fd_n_counter.sv
// Programmable modulus counter for the FMDLL feedback N-divider. A new modulus takes effect only
// at a period boundary. Optional modulus dither: define FD_N_FRAC_DITHER_EN.
module fd_n_counter #(
  parameter int unsigned N_MIN = 2,
  parameter int unsigned N_RST = 2
) (
  input  logic       clk_out,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] N_req,
  input  logic [3:0] N_frac,
  output logic [3:0] N,
  output logic [3:0] N_counter,
  output logic       wrap,
  output logic       upd_done
);

  localparam logic [3:0] NMin = 4'(N_MIN);
  localparam logic [3:0] NRst = 4'(N_RST);

  logic [3:0] cnt_q, cnt_d;
  logic [3:0] n_q, n_d;
  logic [3:0] nint_q, nint_d;
  logic [3:0] pend_val_q, pend_val_d;
  logic       pend_q, pend_d;
  logic       wrap_q, wrap_d;
  logic       upd_q, upd_d;

  logic       terminal;
  logic       apply;
  logic [3:0] base;
  logic [3:0] req_clamped;
  logic [3:0] dith_n;

  assign req_clamped = (N_req < NMin) ? NMin : N_req;
  assign terminal    = (cnt_q == n_q);
  // With the counter stopped no period is in progress, so a pending value applies immediately.
  assign apply       = en ? terminal : pend_q;
  assign base        = pend_q ? pend_val_q : nint_q;

`ifdef FD_N_FRAC_DITHER_EN
  logic [3:0] acc_q, acc_d;
  logic [3:0] frac_q, frac_d;
  logic [3:0] pend_frac_q, pend_frac_d;
  logic [3:0] frac_use;
  logic [4:0] acc_sum;

  assign frac_use = pend_q ? pend_frac_q : frac_q;
  assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_use};

  always_comb begin
    acc_d       = acc_q;
    frac_d      = frac_q;
    pend_frac_d = load ? N_frac : pend_frac_q;
    dith_n      = base;
    if (en && terminal) begin
      acc_d  = acc_sum[3:0];
      frac_d = frac_use;
      // Carry at the top modulus is dropped; the accumulator still advances.
      if (acc_sum[4] && (base != 4'hF)) begin
        dith_n = base + 4'd1;
      end
    end else if (!en && pend_q) begin
      frac_d = pend_frac_q;
    end
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= 4'd0;
      frac_q      <= 4'd0;
      pend_frac_q <= 4'd0;
    end else begin
      acc_q       <= acc_d;
      frac_q      <= frac_d;
      pend_frac_q <= pend_frac_d;
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^N_frac;
  assign dith_n      = base;
`endif

  always_comb begin
    cnt_d      = 4'd0;
    wrap_d     = 1'b0;
    upd_d      = apply & pend_q;
    nint_d     = apply ? base : nint_q;
    n_d        = apply ? dith_n : n_q;
    pend_d     = pend_q & ~apply;
    pend_val_d = pend_val_q;
    if (en) begin
      cnt_d  = terminal ? 4'd0 : cnt_q + 4'd1;
      wrap_d = terminal;
    end
    // A load coinciding with an update is kept pending for the next boundary.
    if (load) begin
      pend_d     = 1'b1;
      pend_val_d = req_clamped;
    end
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 4'd0;
      n_q        <= NRst;
      nint_q     <= NRst;
      pend_q     <= 1'b0;
      pend_val_q <= NRst;
      wrap_q     <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      nint_q     <= nint_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      wrap_q     <= wrap_d;
      upd_q      <= upd_d;
    end
  end

  assign N         = n_q;
  assign N_counter = cnt_q;
  assign wrap      = wrap_q;
  assign upd_done  = upd_q;

endmodule
